// File: rtl/sensor_pkg.sv
// Shared types and constants for the sensor debounce front end.
// State encoding, default debounce depth and glitch counter width.
package sensor_pkg;

   typedef enum logic [1:0] {
      ST_LOW   = 2'd0,
      CHK_HIGH = 2'd1,
      ST_HIGH  = 2'd2,
      CHK_LOW  = 2'd3
   } state_t;

   localparam int SENSOR_DEB_DEFAULT = 8;
   localparam int GLITCH_W           = 8;

endpackage

// File: rtl/sensor_sync.sv
// Generic 1-bit two-flop synchronizer with synchronous reset.
// Reusable for any asynchronous single-bit input.
module sensor_sync (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic dout
);

   logic q1;

   // Two back-to-back flops to settle metastability before use.
   always_ff @(posedge clk) begin
      if (reset) begin
         q1   <= 1'b0;
         dout <= 1'b0;
      end else begin
         q1   <= din;
         dout <= q1;
      end
   end

endmodule

// File: rtl/sensor_debounce.sv
// Synchronizes and debounces a raw sensor line; emits level plus strobes.
// Optional glitch counter port enabled by SENSOR_GLITCH_CNT_EN.
module sensor_debounce
   import sensor_pkg::*;
#(
   parameter  int DEB_CYCLES = SENSOR_DEB_DEFAULT,
   localparam int CNT_W      = $clog2(DEB_CYCLES + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic sensor_in,
   output logic sensor_out,
   output logic rise,
   output logic fall
`ifdef SENSOR_GLITCH_CNT_EN
   ,
   output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state;
   state_t           state_n;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_n;
   logic             q2;
   logic             out_n;
   logic             rise_n;
   logic             fall_n;
   logic             abort;

   sensor_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .din   (sensor_in),
      .dout  (q2)
   );

   // State, counter and registered outputs; reset drops straight to low.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_LOW;
         cnt        <= '0;
         sensor_out <= 1'b0;
         rise       <= 1'b0;
         fall       <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         sensor_out <= out_n;
         rise       <= rise_n;
         fall       <= fall_n;
      end
   end

   // Next state: count identical samples, accept on the last one.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      out_n   = sensor_out;
      rise_n  = 1'b0;
      fall_n  = 1'b0;
      abort   = 1'b0;
      unique case (state)
         ST_LOW: begin
            if (q2) begin
               state_n = CHK_HIGH;
               cnt_n   = CNT_ONE;
            end else begin
               cnt_n = '0;
            end
         end
         CHK_HIGH: begin
            if (!q2) begin
               state_n = ST_LOW;
               cnt_n   = '0;
               abort   = 1'b1;
            end else if (cnt == CNT_LAST) begin
               state_n = ST_HIGH;
               cnt_n   = '0;
               out_n   = 1'b1;
               rise_n  = 1'b1;
            end else begin
               cnt_n = cnt + CNT_ONE;
            end
         end
         ST_HIGH: begin
            if (!q2) begin
               state_n = CHK_LOW;
               cnt_n   = CNT_ONE;
            end else begin
               cnt_n = '0;
            end
         end
         CHK_LOW: begin
            if (q2) begin
               state_n = ST_HIGH;
               cnt_n   = '0;
               abort   = 1'b1;
            end else if (cnt == CNT_LAST) begin
               state_n = ST_LOW;
               cnt_n   = '0;
               out_n   = 1'b0;
               fall_n  = 1'b1;
            end else begin
               cnt_n = cnt + CNT_ONE;
            end
         end
         default: begin
            state_n = ST_LOW;
            cnt_n   = '0;
         end
      endcase
   end

`ifdef SENSOR_GLITCH_CNT_EN
   // Saturating count of checks aborted without a level change.
   always_ff @(posedge clk) begin
      if (reset) begin
         glitch_cnt <= '0;
      end else if (abort && (glitch_cnt != '1)) begin
         glitch_cnt <= glitch_cnt + GLITCH_W'(1);
      end
   end
`else
   logic unused_abort;
   assign unused_abort = abort;
`endif

endmodule

// File: doc/sensor_debounce.md
# sensor_debounce

Front-end conditioning stage directly upstream of the sensor-processing block. It takes the raw, asynchronous sensor line, synchronizes it into the `clk` domain, and rejects glitches shorter than a programmable number of cycles. It then delivers a clean level plus single-cycle rise and fall strobes to the sensor-processing stage. Nominal clock is 100 MHz (10 ns period).

## Interface
- `DEB_CYCLES`, default 8: consecutive identical synchronized samples required to accept a level change; legal range 2..255.
- `CNT_W`, default `$clog2(DEB_CYCLES+1)`: width of the stability counter; derived, not overridden.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sensor_in`  in  1  raw sensor line, asynchronous to `clk`.
- `sensor_out`  out  1  debounced sensor level.
- `rise`  out  1  one-cycle strobe on an accepted 0→1 change.
- `fall`  out  1  one-cycle strobe on an accepted 1→0 change.
- `glitch_cnt`  out  8  saturating count of rejected transitions; present only with `SENSOR_GLITCH_CNT_EN`.

## Operation
- Two-flop synchronizer: `sensor_in` → `q1` → `q2`. The FSM uses only `q2`.
- FSM states: `ST_LOW`, `CHK_HIGH`, `ST_HIGH`, `CHK_LOW`. The stability counter `cnt` is `CNT_W` bits wide.
- `ST_LOW`: when `q2`=1, go to `CHK_HIGH` and load `cnt`=1. Otherwise stay in `ST_LOW` with `cnt`=0.
- `CHK_HIGH` with `q2`=1:
  - If `cnt`==`DEB_CYCLES`-1: go to `ST_HIGH`, register `sensor_out`=1 and `rise`=1, clear `cnt`.
  - Otherwise: increment `cnt`.
- `CHK_HIGH` with `q2`=0: return to `ST_LOW`, clear `cnt`, count one glitch.
- `ST_HIGH` and `CHK_LOW` mirror `ST_LOW` and `CHK_HIGH` with polarity inverted; the accepted change produces `fall`.
- Net rule: a change is accepted only after exactly `DEB_CYCLES` consecutive identical `q2` samples.
- `rise` and `fall` are registered, high for exactly one cycle, and never asserted together.
- `cnt` never exceeds `DEB_CYCLES`-1, so there is no wrap.

## Timing
- Reset values: `q1`, `q2`, `cnt`, `sensor_out`, `rise`, `fall` and `glitch_cnt` are all 0; the FSM is in `ST_LOW`.
- Latency: `sensor_out` changes, and the matching strobe asserts, on the (`DEB_CYCLES`+2)-th rising edge, counting the first edge that samples the new raw level. With the default, that is the 10th edge (100 ns).
- Minimum accepted raw pulse: `DEB_CYCLES` cycles. Any shorter pulse is rejected and produces no strobe.
- Reset asserted mid-check or mid-level:
  - The FSM returns to `ST_LOW` and `sensor_out`=0 immediately on that edge, with no `fall` strobe.
  - If `sensor_in` is still high after reset release, `rise` follows `DEB_CYCLES`+2 edges after release.
- A change on the raw input while a strobe is asserted is legal and handled normally.

## Configuration
- Macro: `SENSOR_GLITCH_CNT_EN`.
- Defined: the `glitch_cnt` port and its 8-bit register exist.
  - It increments on every `CHK_*`→`ST_*` abort without a level change.
  - It saturates at 255 and is cleared only by `reset`.
- Undefined: the port and the register are absent; all other behaviour is identical.

## Structure
- Package `sensor_pkg` holds:
  - the FSM state typedef (2-bit enum of the four states);
  - `SENSOR_DEB_DEFAULT` = 8;
  - `GLITCH_W` = 8.
- Sub-module `sensor_sync`: a generic two-flop synchronizer (1-bit, synchronous reset). It is instantiated once and is reusable for other asynchronous inputs.

## Test plan
- Reset held for 4 cycles with `sensor_in`=1 → all outputs 0 during reset; `rise`=1 for one cycle on the 10th edge after release; `sensor_out` stays 1.
- 10-cycle high pulse from idle → `rise` at edge 10, `sensor_out`=1 for 10 cycles, `fall` 10 cycles after `rise`; `glitch_cnt`=0.
- 5-cycle high pulse → no `rise`, `sensor_out` stays 0, `glitch_cnt`=1.
- `sensor_out`=1, then a 3-cycle low dip → no `fall`, `sensor_out` stays 1, `glitch_cnt` increments by 1.
- 300 alternating 2-cycle pulses → no strobes, `glitch_cnt` saturates at 255.
- `reset` asserted at `cnt`=5 in `CHK_HIGH` → next cycle: state `ST_LOW`, `cnt`=0, no strobe.
